// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t        : FETCH (may issue), WAIT (issued, stalled), HALT
//   RESET_VECTOR_DEFAULT : default PC loaded on reset
//   HALT_ADDR_DEFAULT    : default address whose fetch halts the unit
//   WORD_BYTES           : bytes per instruction word
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;
  localparam int unsigned WORD_BYTES           = 4;

  // Clears the byte-offset bits of an address.
  localparam logic [31:0] WORD_MASK = ~(32'(WORD_BYTES) - 32'd1);

  // Address of the following instruction word; wraps modulo 2^32.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'(WORD_BYTES);
  endfunction

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr & ~WORD_MASK) == 32'd0;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit and its surroundings.
//   mem_*   : word-read port towards instruction memory (Avalon-style waitrequest)
//   instr_* : valid/ready delivery of {pc, instruction} towards decode
// Modports: master = fetch unit side, slave = memory/decode side.
interface instr_fetch_unit_if;

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  modport master (
    output mem_address,
    output mem_read,
    input  mem_waitrequest,
    input  mem_readdata,
    output instr_valid,
    input  instr_ready,
    output instr_data,
    output instr_pc
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    output mem_waitrequest,
    output mem_readdata,
    input  instr_valid,
    output instr_ready,
    input  instr_data,
    input  instr_pc
  );

endinterface

// File: rtl/fetch_buffer.sv
// One-entry {pc, instruction} holding register between memory and decode.
//   clk, reset           : clock, asynchronous active-high reset
//   flush                : drop the held entry (redirect)
//   load, load_pc/_data  : capture a new entry (caller guarantees the slot is free)
//   out_ready            : consumer accepts when out_valid & out_ready
//   out_valid/_pc/_data  : held entry; stable while valid and not accepted
module fetch_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_data
);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values; blocking assignments here would make results depend on statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      // NOTE: the payload is reset as well, so decode sees pc/data of zero rather than X after reset.
      out_pc    <= '0;
      out_data  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (load && !flush) begin
        out_pc   <= load_pc;
        out_data <= load_data;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues word reads starting at
// RESET_VECTOR, rides out memory wait states, and hands {pc, instruction}
// to decode through a one-entry buffer. Execute can redirect the PC; the
// unit halts once the PC reaches HALT_ADDR and only reset restarts it.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   bus (master)        : mem_* read port and instr_* delivery port
//   redirect_valid/_pc  : one-cycle PC replacement from execute
//   active              : 1 while running, 0 once halted
//   fetch_exc/_badvaddr : misaligned-fetch trap (0 unless enabled)
// Build option: define FETCH_MISALIGN_TRAP_EN to trap on a misaligned PC
// instead of silently word-aligning redirect targets.
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  instr_fetch_unit_if.master        bus,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      active,
  output logic                      fetch_exc,
  output logic [31:0]               fetch_badvaddr
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  wait_addr;   // address of the stalled transfer, frozen while in WAIT
  logic         discard;     // stalled transfer belongs to a path abandoned by redirect

  logic         buf_valid;
  logic [31:0]  buf_pc;
  logic [31:0]  buf_data;

  logic         issue;
  logic         stall;
  logic         accept;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic         buf_load;
  logic         buf_flush;
  logic         pc_fetchable;
  logic [31:0]  redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_target = redirect_pc;
  assign pc_fetchable    = word_aligned(pc);
`else
  assign redirect_target = redirect_pc & WORD_MASK;
  assign pc_fetchable    = 1'b1;
`endif

  // Request logic is combinational so a consume and a new read can share a
  // cycle, giving one instruction per cycle from zero-wait memory.
  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    issue       = 1'b0;
    mem_read    = 1'b0;
    mem_address = pc;
    if (state == FETCH) begin
      issue = !reset && (!buf_valid || bus.instr_ready)
              && (pc != HALT_ADDR) && pc_fetchable;
      mem_read = issue;
    end else if (state == WAIT) begin
      mem_read    = 1'b1;
      mem_address = wait_addr;
    end
  end

  assign stall     = mem_read && bus.mem_waitrequest;
  assign accept    = mem_read && !bus.mem_waitrequest;
  // Data of a redirected-away path never reaches the buffer.
  assign buf_load  = accept && !discard && !redirect_valid;
  assign buf_flush = redirect_valid && (state != HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_VECTOR;
      wait_addr <= '0;
      discard   <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (stall) begin
            state     <= WAIT;
            wait_addr <= pc;
          end
          if (redirect_valid) begin
            pc      <= redirect_target;
            // A read presented but not yet accepted must still complete.
            discard <= stall;
          end else if (pc == HALT_ADDR) begin
            state <= HALT;
          end else if (accept) begin
            pc <= next_word(pc);
          end
        end
        WAIT: begin
          if (accept) begin
            state   <= FETCH;
            discard <= 1'b0;
          end
          if (redirect_valid) begin
            pc <= redirect_target;
            if (!accept) discard <= 1'b1;
          end else if (accept && !discard) begin
            pc <= next_word(pc);
          end
        end
        HALT: begin
          // Only reset leaves HALT; redirects are ignored.
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        exc_q;
  logic [31:0] badvaddr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_q      <= 1'b0;
      badvaddr_q <= '0;
    end else if (redirect_valid && state != HALT) begin
      exc_q      <= 1'b0;
      badvaddr_q <= '0;
    end else if (state == FETCH && !pc_fetchable && pc != HALT_ADDR) begin
      exc_q      <= 1'b1;
      badvaddr_q <= pc;
    end
  end

  assign fetch_exc      = exc_q;
  assign fetch_badvaddr = badvaddr_q;
`else
  assign fetch_exc      = 1'b0;
  assign fetch_badvaddr = '0;
`endif

  fetch_buffer u_buffer (
    .clk       (clk),
    .reset     (reset),
    .flush     (buf_flush),
    .load      (buf_load),
    .load_pc   (mem_address),
    .load_data (bus.mem_readdata),
    .out_ready (bus.instr_ready),
    .out_valid (buf_valid),
    .out_pc    (buf_pc),
    .out_data  (buf_data)
  );

  assign bus.mem_read    = mem_read;
  assign bus.mem_address = mem_address;
  assign bus.instr_valid = buf_valid;
  assign bus.instr_pc    = buf_pc;
  assign bus.instr_data  = buf_data;
  assign active          = (state != HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: reset values, a table of
// per-cycle vectors for the start-up/wait-state/backpressure sequence,
// hand-written redirect/halt/wrap/misalign sequences, and a randomized run
// scored against an instruction-stream model (expected next PC).
module tb_instr_fetch_unit;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        active;
  logic        fetch_exc;
  logic [31:0] fetch_badvaddr;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit_if bus();

  always #5 clk = ~clk;

  // Combinational ROM: content is a fixed scramble of the address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.mem_readdata = rom_word(bus.mem_address);

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .active         (active),
    .fetch_exc      (fetch_exc),
    .fetch_badvaddr (fetch_badvaddr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are then sampled
  // 2 ns later, well before the next rising edge.
  task automatic step(input logic rdy, input logic wreq, input logic rdv, input logic [31:0] rpc);
    @(negedge clk);
    reset               = 1'b0;
    bus.instr_ready     = rdy;
    bus.mem_waitrequest = wreq;
    redirect_valid      = rdv;
    redirect_pc         = rpc;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset               = 1'b1;
    bus.instr_ready     = 1'b0;
    bus.mem_waitrequest = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    #2;
  endtask

  task automatic expect_bus(input string tag, input logic rd, input logic [31:0] addr,
                            input logic vld, input logic [31:0] ipc);
    check_bit({tag, "_rd"}, bus.mem_read, rd);
    if (rd) check({tag, "_addr"}, bus.mem_address, addr);
    check_bit({tag, "_vld"}, bus.instr_valid, vld);
    if (vld) begin
      check({tag, "_pc"}, bus.instr_pc, ipc);
      check({tag, "_data"}, bus.instr_data, rom_word(ipc));
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        wreq;
    logic        exp_rd;
    logic [31:0] exp_addr;
    logic        exp_vld;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[13];

  task automatic run_random(input int cycles);
    logic [31:0] exp_next;
    logic [31:0] prev_addr;
    logic [31:0] tgt;
    logic        prev_stall;
    logic        rdy;
    logic        wreq;
    logic        rdv;
    int          deliveries;
    exp_next   = RV;
    prev_addr  = '0;
    prev_stall = 1'b0;
    deliveries = 0;
    for (int c = 0; c < cycles; c++) begin
      rdy  = ($urandom_range(3) != 0);
      wreq = ($urandom_range(9) < 3);
      rdv  = ($urandom_range(31) == 0);
      tgt  = RV | {20'd0, 12'($urandom_range(4095)) & 12'hFFC};
      step(rdy, wreq, rdv, tgt);
      // A stalled request must be repeated unchanged.
      if (prev_stall) begin
        check_bit("rand_hold_rd", bus.mem_read, 1'b1);
        check("rand_hold_addr", bus.mem_address, prev_addr);
      end
      if (bus.mem_read) check("rand_align", bus.mem_address & 32'h3, 32'h0);
      // Delivered stream must be sequential from the last redirect target.
      if (bus.instr_valid && rdy) begin
        check("rand_pc", bus.instr_pc, exp_next);
        check("rand_data", bus.instr_data, rom_word(exp_next));
        exp_next = exp_next + 32'd4;
        deliveries++;
      end
      if (rdv) exp_next = tgt;
      prev_stall = bus.mem_read && wreq;
      prev_addr  = bus.mem_address;
    end
    check_bit("rand_progress", deliveries >= 300, 1'b1);
  endtask

  initial begin
    bus.instr_ready     = 1'b0;
    bus.mem_waitrequest = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'hBFC0_0004, 1'b1, 32'hBFC0_0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'hBFC0_0004, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'hBFC0_0004, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'hBFC0_0004, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0004};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0004};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0004};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0004};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0004};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0004};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 32'hBFC0_000C, 1'b1, 32'hBFC0_0008};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_000C};

    // Reset values while reset is held.
    do_reset();
    check_bit("rst_rd", bus.mem_read, 1'b0);
    check_bit("rst_vld", bus.instr_valid, 1'b0);
    check("rst_data", bus.instr_data, 32'h0);
    check("rst_pc", bus.instr_pc, 32'h0);
    check_bit("rst_active", active, 1'b1);
    check_bit("rst_exc", fetch_exc, 1'b0);
    check("rst_badv", fetch_badvaddr, 32'h0);

    // Start-up stream, 3 wait states on BFC00004, 5 cycles of backpressure.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rdy, vecs[i].wreq, 1'b0, 32'h0);
      expect_bus($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_addr,
                 vecs[i].exp_vld, vecs[i].exp_pc);
      check_bit($sformatf("vec%0d_active", i), active, 1'b1);
    end

    // Redirect while stalled on BFC00008: old read completes, is dropped.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_bus("redw_c1", 1'b1, 32'hBFC0_0004, 1'b1, 32'hBFC0_0000);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    expect_bus("redw_c2", 1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0004);
    step(1'b1, 1'b1, 1'b1, 32'hBFC0_0100);
    expect_bus("redw_c3", 1'b1, 32'hBFC0_0008, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    expect_bus("redw_c4", 1'b1, 32'hBFC0_0008, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_bus("redw_c5", 1'b1, 32'hBFC0_0008, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_bus("redw_c6", 1'b1, 32'hBFC0_0100, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_bus("redw_c7", 1'b1, 32'hBFC0_0104, 1'b1, 32'hBFC0_0100);

    // Redirect to the halt address: no read of 0, halts, ignores redirects.
    do_reset();
    step(1'b1, 1'b0, 1'b1, 32'h0);
    expect_bus("halt_c0", 1'b1, RV, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_bus("halt_c1", 1'b0, 32'h0, 1'b0, 32'h0);
    check_bit("halt_c1_active", active, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_bit("halt_c2_active", active, 1'b0);
    check_bit("halt_c2_rd", bus.mem_read, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'hBFC0_0100);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check_bit($sformatf("halt_stay%0d_active", i), active, 1'b0);
      check_bit($sformatf("halt_stay%0d_rd", i), bus.mem_read, 1'b0);
    end

    // PC wraps from FFFFFFFC to the halt address; buffered word still delivered.
    do_reset();
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_bus("wrap_c1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    expect_bus("wrap_c2", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    check_bit("wrap_c2_active", active, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_bus("wrap_c3", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    check_bit("wrap_c3_active", active, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_bus("wrap_c4", 1'b0, 32'h0, 1'b0, 32'h0);

    // Misaligned redirect target.
    do_reset();
    step(1'b1, 1'b0, 1'b1, 32'hBFC0_0102);
    step(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_bit("mis_c1_rd", bus.mem_read, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_bit("mis_c2_rd", bus.mem_read, 1'b0);
    check_bit("mis_c2_exc", fetch_exc, 1'b1);
    check("mis_c2_badv", fetch_badvaddr, 32'hBFC0_0102);
    step(1'b1, 1'b0, 1'b1, 32'hBFC0_0200);
    check_bit("mis_c3_exc", fetch_exc, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_bit("mis_c4_exc", fetch_exc, 1'b0);
    check("mis_c4_badv", fetch_badvaddr, 32'h0);
    expect_bus("mis_c4", 1'b1, 32'hBFC0_0200, 1'b0, 32'h0);
`else
    expect_bus("mis_c1", 1'b1, 32'hBFC0_0100, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    expect_bus("mis_c2", 1'b1, 32'hBFC0_0104, 1'b1, 32'hBFC0_0100);
    check_bit("mis_c2_exc", fetch_exc, 1'b0);
    check("mis_c2_badv", fetch_badvaddr, 32'h0);
`endif

    // Randomized waits, backpressure and redirects against the stream model.
    do_reset();
    run_random(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
